// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Constants shared by the Basic Computer memory loader slice.
// Contents:
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default memory geometry (4096 x 16)
//   SYNC_BYTE_DEF                   : frame start marker
//   MAX_COUNT / COUNT_WIDTH         : largest legal word count and its field width
//   ST_*                            : loader FSM state encodings
//   state_accepts_bytes()           : states in which the loader takes a byte
// ---------------------------------------------------------------------------
package bc_pkg;

  localparam int         ADDR_WIDTH_DEF = 12;
  localparam int         DATA_WIDTH_DEF = 16;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  // The count field is 13 bits wide so that a full 4096-word load is expressible.
  localparam int COUNT_WIDTH = 13;
  localparam int MAX_COUNT   = 4096;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_A_HI  = 4'd1;
  localparam logic [3:0] ST_A_LO  = 4'd2;
  localparam logic [3:0] ST_N_HI  = 4'd3;
  localparam logic [3:0] ST_N_LO  = 4'd4;
  localparam logic [3:0] ST_D_HI  = 4'd5;
  localparam logic [3:0] ST_D_LO  = 4'd6;
  localparam logic [3:0] ST_WRITE = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  // WRITE and DONE are the only states that cannot take a byte; there is no
  // byte buffer, so the host must wait them out.
  function automatic logic state_accepts_bytes(input logic [3:0] st);
    return (st != ST_WRITE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// ---------------------------------------------------------------------------
// mem_port_mux
// Combinational owner select for the memory's single write port.
// Ports:
//   sel_loader        : 1 = loader owns the port, 0 = CPU passes straight through
//   cpu_write_enable, cpu_address, cpu_write_data : CPU side request
//   ld_write_enable,  ld_address,  ld_write_data  : loader side request
//   mem_write_enable, mem_address, mem_write_data : to the memory
// ---------------------------------------------------------------------------
module mem_port_mux
  import bc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  sel_loader,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  ld_write_enable,
  input  logic [ADDR_WIDTH-1:0] ld_address,
  input  logic [DATA_WIDTH-1:0] ld_write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  // While the loader owns the port the CPU request is dropped entirely, so a
  // stalled CPU that still asserts write_enable cannot corrupt the load.
  assign mem_write_enable = sel_loader ? ld_write_enable : cpu_write_enable;
  assign mem_address      = sel_loader ? ld_address      : cpu_address;
  assign mem_write_data   = sel_loader ? ld_write_data   : cpu_write_data;

endmodule

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Parses a framed byte stream (SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then
// CNT words high byte first) and writes the words to consecutive memory
// locations through the memory's single write port, holding the CPU while a
// frame is in progress.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_data, in_valid : byte stream from the host link
//   in_ready          : a byte is consumed when in_valid && in_ready
//   cpu_*             : CPU memory request, passed through when not loading
//   mem_*             : to the memory write port
//   cpu_hold          : CPU must stall (registered, high for the whole frame)
//   load_done         : one-cycle pulse when a frame completes
//   load_error        : one-cycle pulse when a frame header is rejected
// ---------------------------------------------------------------------------
module mem_loader
  import bc_pkg::*;
#(
  parameter int         ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // Only the low header bits that feed the address or the count are kept;
  // the rest of ADDR_HI / CNT_HI is ignored by definition of the frame.
  localparam int HDR_HI_W = (ADDR_WIDTH > COUNT_WIDTH) ? (ADDR_WIDTH - 8) : (COUNT_WIDTH - 8);

  logic [3:0]             state_reg;
  logic [3:0]             state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [COUNT_WIDTH-1:0] remaining_reg;
  logic [HDR_HI_W-1:0]    hdr_hi_reg;
  logic [7:0]             data_hi_reg;
  logic [7:0]             data_lo_reg;
  logic                   hold_reg;

  logic                   consume;
  logic [COUNT_WIDTH-1:0] count_field;
  logic                   count_bad;
  logic                   error_pulse;
  logic                   ld_write_enable;
  logic [DATA_WIDTH-1:0]  ld_write_data;

  // in_ready is forced low during the reset cycle so no byte is lost into a
  // state that is about to be cleared.
  assign in_ready = ~reset & state_accepts_bytes(state_reg);
  assign consume  = in_valid & in_ready;

  // Count is assembled from the held CNT_HI bits and the CNT_LO byte on the bus.
  assign count_field = COUNT_WIDTH'({hdr_hi_reg, in_data});
  assign count_bad   = (count_field == '0) || (count_field > COUNT_WIDTH'(MAX_COUNT));

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    error_pulse = 1'b0;
    case (state_reg)
      ST_IDLE:  if (consume && (in_data == SYNC_BYTE)) state_next = ST_A_HI;
      ST_A_HI:  if (consume) state_next = ST_A_LO;
      ST_A_LO:  if (consume) state_next = ST_N_HI;
      ST_N_HI:  if (consume) state_next = ST_N_LO;
      ST_N_LO: begin
        if (consume) begin
          if (count_bad) begin
            // The rejection pulse is issued in the consuming cycle, while
            // cpu_hold is still high; the CPU is released on the next cycle.
            error_pulse = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            state_next = ST_D_HI;
          end
        end
      end
      ST_D_HI:  if (consume) state_next = ST_D_LO;
      ST_D_LO:  if (consume) state_next = ST_WRITE;
      ST_WRITE: state_next = (remaining_reg == COUNT_WIDTH'(1)) ? ST_DONE : ST_D_HI;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= 1'b0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      hdr_hi_reg    <= '0;
      data_hi_reg   <= '0;
      data_lo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Hold follows the FSM one cycle late: set after SYNC is taken, cleared
      // on re-entry to IDLE.
      hold_reg  <= (state_next != ST_IDLE);

      if (consume) begin
        case (state_reg)
          ST_A_HI, ST_N_HI: hdr_hi_reg    <= in_data[HDR_HI_W-1:0];
          ST_A_LO:          addr_reg      <= ADDR_WIDTH'({hdr_hi_reg, in_data});
          ST_N_LO:          remaining_reg <= count_field;
          ST_D_HI:          data_hi_reg   <= in_data;
          ST_D_LO:          data_lo_reg   <= in_data;
          default:          ;
        endcase
      end

      // Address wraps naturally at the top of memory.
      if (state_reg == ST_WRITE) begin
        addr_reg      <= addr_reg + ADDR_WIDTH'(1);
        remaining_reg <= remaining_reg - COUNT_WIDTH'(1);
      end
    end
  end

  // Reset gates the write strobe and the pulses so an abort mid-frame never
  // produces a write, done or error in the reset cycle itself.
  assign ld_write_enable = (state_reg == ST_WRITE) & ~reset;
  assign ld_write_data   = DATA_WIDTH'({data_hi_reg, data_lo_reg});
  assign load_done       = (state_reg == ST_DONE) & ~reset;
  assign load_error      = error_pulse;
  assign cpu_hold        = hold_reg;

  mem_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_port_mux (
    .sel_loader       (hold_reg),
    .cpu_write_enable (cpu_write_enable),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .ld_write_enable  (ld_write_enable),
    .ld_address       (addr_reg),
    .ld_write_data    (ld_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data)
  );

endmodule
